// File: rtl/stdp_pkg.sv
// stdp_pkg: shared types and arithmetic helpers for the STDP synapse array
package stdp_pkg;

    typedef enum logic {
        LTD = 1'b0,
        LTP = 1'b1
    } kind_e;

    // Amplitude halves once per 2^tau cycles of dt and vanishes once the shift reaches the weight width
    function automatic int dw_shift(input int amp, input int dt, input int tau, input int ww);
        int sh;
        sh = dt >> tau;
        return (sh >= ww) ? 0 : amp >> sh;
    endfunction

    function automatic int sat_add(input int w, input int dw, input int hi);
        return (w + dw > hi) ? hi : w + dw;
    endfunction

    function automatic int sat_sub(input int w, input int dw, input int lo);
        return (w < dw + lo) ? lo : w - dw;
    endfunction

endpackage

// File: rtl/stdp_dw_lut.sv
// stdp_dw_lut: weight step for a captured spike-time difference and update kind
module stdp_dw_lut
    import stdp_pkg::*;
#(
    parameter int TW        = 6,
    parameter int WW        = 8,
    parameter int TAU_SHIFT = 2,
    parameter int A_PLUS    = 16,
    parameter int A_MINUS   = 12
) (
    input  logic [TW-1:0] dt,
    input  logic          kind,
    output logic [WW-1:0] dw
);

    assign dw = WW'(dw_shift(kind ? A_PLUS : A_MINUS, 32'(dt), TAU_SHIFT, WW));

endmodule

// File: rtl/stdp_array.sv
// stdp_array: multi-synapse STDP learning with shift-decayed, saturating weight updates
module stdp_array
    import stdp_pkg::*;
#(
    parameter int N_SYN     = 4,
    parameter int WW        = 8,
    parameter int TW        = 6,
    parameter int WINDOW    = 32,
    parameter int TAU_SHIFT = 2,
    parameter int A_PLUS    = 16,
    parameter int A_MINUS   = 12,
    parameter int W_INIT    = 64,
    parameter int W_MIN     = 0,
    parameter int W_MAX     = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     learn_en,
    input  logic [N_SYN-1:0]         pre_spike,
    input  logic                     post_spike,
    output logic [N_SYN*WW-1:0]      weight,
    output logic                     upd_valid,
    output logic [$clog2(N_SYN)-1:0] upd_idx,
    output logic                     upd_ltp,
    output logic [WW-1:0]            upd_dw,
    output logic                     busy,
    output logic                     ovr
);

    localparam int IW = $clog2(N_SYN);
    localparam logic [TW-1:0] T_SAT = '1;
    localparam logic [TW-1:0] WIN = TW'(WINDOW);
    localparam logic [WW-1:0] W0 = WW'(W_INIT);

    logic [TW-1:0]    post_t;
    logic [TW-1:0]    post_nxt;
    logic [N_SYN-1:0] ltp_pend;
    logic [N_SYN-1:0] ltd_pend;
    logic [N_SYN-1:0] ltp_set;
    logic [N_SYN-1:0] ltd_set;
    logic [N_SYN-1:0] ltp_clr;
    logic [N_SYN-1:0] ltd_clr;
    logic [N_SYN-1:0] any_pend;
    logic [TW-1:0]    ltp_dt [N_SYN];
    logic [TW-1:0]    ltd_dt [N_SYN];
    logic [IW-1:0]    rr;
    logic [IW-1:0]    pick;
    logic             found;
    int               rr_j;
    logic             s_valid;
    logic [IW-1:0]    s_idx;
    kind_e            s_kind;
    logic [TW-1:0]    s_dt;
    logic [WW-1:0]    w [N_SYN];
    logic [WW-1:0]    dw;
    logic [WW-1:0]    w_cur;
    logic [WW-1:0]    w_new;

    // Next timer value doubles as the captured dt: 0 on a same-edge spike, else timer+1 saturating
    assign post_nxt = post_spike ? '0 : (post_t == T_SAT ? T_SAT : post_t + 1'b1);
    assign any_pend = ltp_pend | ltd_pend;
    assign busy     = |any_pend | s_valid | upd_valid;

    for (genvar i = 0; i < N_SYN; i++) begin : g_syn
        logic [TW-1:0] pre_t;
        logic [TW-1:0] pre_nxt;
        logic          lp;
        logic          ld;
        logic [TW-1:0] lp_dt;
        logic [TW-1:0] ld_dt;

        assign pre_nxt     = pre_spike[i] ? '0 : (pre_t == T_SAT ? T_SAT : pre_t + 1'b1);
        assign ltp_set[i]  = learn_en && post_spike && pre_nxt <= WIN;
        assign ltd_set[i]  = learn_en && pre_spike[i] && !post_spike && post_nxt <= WIN;
        assign ltp_clr[i]  = found && pick == IW'(i) && lp;
        assign ltd_clr[i]  = found && pick == IW'(i) && !lp;
        assign ltp_pend[i] = lp;
        assign ltd_pend[i] = ld;
        assign ltp_dt[i]   = lp_dt;
        assign ltd_dt[i]   = ld_dt;
        assign weight[i*WW +: WW] = w[i];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pre_t <= T_SAT;
                lp    <= 1'b0;
                ld    <= 1'b0;
                lp_dt <= '0;
                ld_dt <= '0;
            end else begin
                pre_t <= pre_nxt;
                lp    <= ltp_set[i] | (lp & !ltp_clr[i]);
                ld    <= ltd_set[i] | (ld & !ltd_clr[i]);
                if (ltp_set[i])
                    lp_dt <= pre_nxt;
                if (ltd_set[i])
                    ld_dt <= post_nxt;
            end
        end
    end

    // Scan backwards so the last hit is the first pending synapse at or after rr
    always_comb begin
        found = 1'b0;
        pick  = '0;
        rr_j  = 0;
        for (int k = N_SYN - 1; k >= 0; k--) begin
            rr_j = int'(rr) + k;
            rr_j = rr_j >= N_SYN ? rr_j - N_SYN : rr_j;
            if (any_pend[rr_j]) begin
                found = 1'b1;
                pick  = IW'(rr_j);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            post_t  <= T_SAT;
            rr      <= '0;
            s_valid <= 1'b0;
            s_idx   <= '0;
            s_kind  <= LTD;
            s_dt    <= '0;
            ovr     <= 1'b0;
        end else begin
            post_t  <= post_nxt;
            ovr     <= |((ltp_set & ltp_pend & ~ltp_clr) | (ltd_set & ltd_pend & ~ltd_clr));
            s_valid <= found;
            if (found) begin
                s_idx  <= pick;
                s_kind <= ltp_pend[pick] ? LTP : LTD;
                s_dt   <= ltp_pend[pick] ? ltp_dt[pick] : ltd_dt[pick];
                rr     <= pick == IW'(N_SYN - 1) ? '0 : pick + 1'b1;
            end
        end
    end

    stdp_dw_lut #(
        .TW       (TW),
        .WW       (WW),
        .TAU_SHIFT(TAU_SHIFT),
        .A_PLUS   (A_PLUS),
        .A_MINUS  (A_MINUS)
    ) u_dw (
        .dt  (s_dt),
        .kind(s_kind == LTP),
        .dw  (dw)
    );

    assign w_cur = w[s_idx];
    assign w_new = s_kind == LTP ? WW'(sat_add(32'(w_cur), 32'(dw), W_MAX))
                                 : WW'(sat_sub(32'(w_cur), 32'(dw), W_MIN));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_SYN; k++)
                w[k] <= W0;
            upd_valid <= 1'b0;
            upd_idx   <= '0;
            upd_ltp   <= 1'b0;
            upd_dw    <= '0;
        end else begin
            upd_valid <= s_valid;
            if (s_valid) begin
                w[s_idx] <= w_new;
                upd_idx  <= s_idx;
                upd_ltp  <= s_kind == LTP;
                upd_dw   <= dw;
            end
        end
    end

endmodule
